rc4_avalon_stream_ctrl: RTL and testbench



---
 rtl/rc4_pkg.sv | 31 +++
 rtl/rc4_avalon_stream_ctrl_if.sv | 20 ++
 rtl/rc4_sync_fifo.sv | 46 ++++
 rtl/rc4_avalon_stream_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rc4_avalon_stream_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// Register map, control/status bit positions and FSM states shared by the
// RC4 Avalon stream controller and its bench.
package rc4_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_KEY    = 2'd1;
  localparam logic [1:0] ADDR_STREAM = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int CTRL_START      = 0;
  localparam int CTRL_SOFT_RESET = 1;
  localparam int CTRL_CLEAR_KEY  = 2;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_BUSY       = 2;
  localparam int ST_KEY_OVF    = 3;
  localparam int ST_UNDERFLOW  = 4;
  localparam int ST_GEN        = 5;
  localparam int ST_COUNT_LSB  = 8;
  localparam int ST_KEYLEN_LSB = 16;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    KEYLOAD,
    WAITRDY,
    GEN
  } rc4_state_e;

endpackage

// File: rtl/rc4_avalon_stream_ctrl_if.sv
// Avalon-MM slave bus between the HPS lightweight bridge and the RC4 controller.
interface rc4_avalon_stream_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata
  );
endinterface

// File: rtl/rc4_sync_fifo.sv
// Single-clock show-ahead FIFO; flush empties it in one cycle.
module rc4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/rc4_avalon_stream_ctrl.sv
// Avalon-MM front end for the RC4 core: buffers the key, sequences the core
// and queues keystream bytes for software to drain with plain reads.
//
// state   | meaning
// IDLE    | waiting for START; key buffer writable
// CRST    | core held in reset for one cycle
// KEYLOAD | one key byte strobed into the core per cycle
// WAITRDY | core running its key schedule, waiting for core_ready
// GEN     | pulling keystream bytes into the FIFO
module rc4_avalon_stream_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_MAX_LEN = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  rc4_avalon_stream_ctrl_if.slave avs,
  output logic                    core_reset_n,
  output logic                    core_enable,
  output logic [7:0]              core_keydata,
  input  logic                    core_ready,
  input  logic [7:0]              core_streamvalue
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int KAW = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;

  rc4_state_e state, state_next;

  logic [7:0]       key_mem [KEY_MAX_LEN];
  logic [7:0]       key_len;
  logic [7:0]       idx;
  logic             pulse_prev;
  logic [CNT_W-1:0] byte_cnt;
  logic             key_ovf;
  logic             underflow;
  logic             push;

  logic             wr_en, rd_en, ctrl_hit;
  logic             soft_rst, clear_key, start, key_wr, key_full, cnt_clr, stream_rd;
  logic [31:0]      status;

  logic [7:0]       fifo_head;
  logic [FAW:0]     fifo_count;
  logic             fifo_full, fifo_empty;

  assign wr_en     = avs.chipselect && avs.write;
  assign rd_en     = avs.chipselect && avs.read;
  assign ctrl_hit  = wr_en && (avs.address == ADDR_CTRL) && avs.byteenable[0];
  assign soft_rst  = ctrl_hit && avs.writedata[CTRL_SOFT_RESET];
  assign clear_key = ctrl_hit && avs.writedata[CTRL_CLEAR_KEY] && (state == IDLE);
  assign start     = ctrl_hit && avs.writedata[CTRL_START];
  assign key_wr    = wr_en && (avs.address == ADDR_KEY) && avs.byteenable[0] && (state == IDLE);
  assign key_full  = (key_len == 8'(KEY_MAX_LEN));
  assign cnt_clr   = wr_en && (avs.address == ADDR_COUNT);
  assign stream_rd = rd_en && (avs.address == ADDR_STREAM);

  always_comb begin
    state_next   = state;
    push         = 1'b0;
    core_enable  = 1'b0;
    core_keydata = 8'h00;
    case (state)
      IDLE: begin
        // a CLEAR_KEY in the same word empties the key first, so START is moot
        if (start && !clear_key && key_len != 8'd0) state_next = CRST;
      end
      CRST: state_next = KEYLOAD;
      KEYLOAD: begin
        core_enable  = 1'b1;
        core_keydata = key_mem[idx[KAW-1:0]];
        if (idx == key_len - 8'd1) state_next = WAITRDY;
      end
      WAITRDY: begin
        if (core_ready) state_next = GEN;
      end
      GEN: begin
        push        = core_ready && !fifo_full && !pulse_prev;
        core_enable = push;
      end
      default: state_next = IDLE;
    endcase
    if (soft_rst) begin
      state_next  = IDLE;
      push        = 1'b0;
      core_enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= 8'd0;
      pulse_prev   <= 1'b0;
      core_reset_n <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= (state == KEYLOAD) ? idx + 8'd1 : 8'd0;
      pulse_prev   <= push;
      core_reset_n <= !(soft_rst || state_next == CRST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_len <= 8'd0;
    end else if (clear_key) begin
      key_len <= 8'd0;
    end else if (key_wr && !key_full) begin
      key_len <= key_len + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (key_wr && !key_full) key_mem[key_len[KAW-1:0]] <= avs.writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n || soft_rst) begin
      key_ovf   <= 1'b0;
      underflow <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      if (key_wr && key_full)     key_ovf   <= 1'b1;
      if (stream_rd && fifo_empty) underflow <= 1'b1;
      if (cnt_clr)                byte_cnt  <= '0;
      else if (push)              byte_cnt  <= byte_cnt + 1'b1;
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_NOT_EMPTY]           = !fifo_empty;
    status[ST_FULL]                = fifo_full;
    status[ST_BUSY]                = (state != IDLE) && (state != GEN);
    status[ST_KEY_OVF]             = key_ovf;
    status[ST_UNDERFLOW]           = underflow;
    status[ST_GEN]                 = (state == GEN);
    status[ST_COUNT_LSB +: 8]      = 8'(fifo_count);
    status[ST_KEYLEN_LSB +: 9]     = {1'b0, key_len};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avs.readdata <= 32'h0;
    end else if (rd_en) begin
      case (avs.address)
        ADDR_CTRL:   avs.readdata <= status;
        ADDR_STREAM: avs.readdata <= fifo_empty ? 32'h0 : {23'h0, 1'b1, fifo_head};
        ADDR_COUNT:  avs.readdata <= 32'(byte_cnt);
        default:     avs.readdata <= 32'h0;
      endcase
    end
  end

  rc4_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (soft_rst),
    .push    (push),
    .din     (core_streamvalue),
    .pop     (stream_rd),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_rc4_avalon_stream_ctrl.sv
// Bench for rc4_avalon_stream_ctrl: behavioural RC4 core plus a keystream
// scoreboard, random keys and read counts, and literal "Key" vectors.
module tb_rc4_avalon_stream_ctrl;
  import rc4_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       core_reset_n;
  logic       core_enable;
  logic [7:0] core_keydata;
  logic       core_ready = 1'b0;
  logic [7:0] core_streamvalue = 8'h00;

  rc4_avalon_stream_ctrl_if bus();

  rc4_avalon_stream_ctrl #(.KEY_MAX_LEN(16), .FIFO_DEPTH(16), .CNT_W(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs              (bus),
    .core_reset_n     (core_reset_n),
    .core_enable      (core_enable),
    .core_keydata     (core_keydata),
    .core_ready       (core_ready),
    .core_streamvalue (core_streamvalue)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // RC4 keystream byte at position pos (0 = first byte) for key k
  function automatic logic [7:0] rc4_byte(input logic [7:0] k[$], input int pos);
    int s[256];
    int i, j, t;
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + s[a] + int'(k[a % k.size()])) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n <= pos; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    return 8'(s[(s[i] + s[j]) % 256]);
  endfunction

  // behavioural RC4 core: latches key bytes, then serves bytes with random latency
  logic [7:0] ck_q[$];
  int         c_pos = 0;
  int         c_delay = 0;
  logic       c_loaded = 1'b0;

  always @(posedge clk) begin
    if (core_reset_n !== 1'b1) begin
      ck_q.delete();
      c_pos      <= 0;
      c_loaded   <= 1'b0;
      c_delay    <= 0;
      core_ready <= 1'b0;
    end else if (core_enable && !c_loaded) begin
      ck_q.push_back(core_keydata);
    end else if (core_enable) begin
      core_ready <= 1'b0;
      c_pos      <= c_pos + 1;
      c_delay    <= int'($urandom_range(1, 3));
    end else if (!c_loaded && ck_q.size() != 0) begin
      c_loaded <= 1'b1;
      c_delay  <= int'($urandom_range(2, 6));
    end else if (c_delay == 1) begin
      core_ready       <= 1'b1;
      core_streamvalue <= rc4_byte(ck_q, c_pos);
      c_delay          <= 0;
    end else if (c_delay > 1) begin
      c_delay <= c_delay - 1;
    end
  end

  // compare process
  logic        rd_d = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  exp_key[$];
  int          kidx = 0;
  int          n_crst = 0;
  int          n_pulse = 0;

  always @(posedge clk) rd_d <= bus.chipselect && bus.read;

  always @(negedge clk) begin
    if (rd_d && exp_q.size() != 0) chk(name_q.pop_front(), bus.readdata, exp_q.pop_front());
    if (reset_n) begin
      if (!core_reset_n) begin
        kidx   <= 0;
        n_crst <= n_crst + 1;
      end else if (core_enable && !c_loaded) begin
        chk("keydata", {24'h0, core_keydata},
            (kidx < exp_key.size()) ? {24'h0, exp_key[kidx]} : 32'h100);
        kidx <= kidx + 1;
      end else if (core_enable) begin
        chk("enable_needs_ready", {31'h0, core_ready}, 32'h1);
        n_pulse <= n_pulse + 1;
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a;
    bus.writedata = d; bus.byteenable = be;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp); name_q.push_back(nm);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic load_key(input int extra);
    foreach (exp_key[i]) bus_write(ADDR_KEY, {24'h0, exp_key[i]}, 4'hF);
    repeat (extra) bus_write(ADDR_KEY, 32'(($urandom & 8'hFF)), 4'hF);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] lit [8] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72};

  initial begin
    int c0, p0, klen, nrd;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = 2'd0; bus.byteenable = 4'h0; bus.writedata = 32'h0;
    cycles(3);
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_core_reset_n", {31'h0, core_reset_n}, 32'h0);
    chk("rst_core_enable", {31'h0, core_enable}, 32'h0);
    chk("rst_core_keydata", {24'h0, core_keydata}, 32'h0);
    reset_n = 1'b1;
    cycles(2);
    bus_read(ADDR_CTRL, 32'h0, "status_after_reset");
    bus_read(ADDR_COUNT, 32'h0, "count_after_reset");

    bus_read(ADDR_STREAM, 32'h0, "stream_empty");
    bus_read(ADDR_CTRL, 32'h10, "status_underflow");
    bus_write(ADDR_CTRL, 32'h2, 4'hE);
    bus_write(ADDR_KEY, 32'h4B, 4'hE);
    bus_read(ADDR_CTRL, 32'h10, "byteenable0_low_ignored");
    bus_write(ADDR_CTRL, 32'h2, 4'hF);
    bus_read(ADDR_CTRL, 32'h0, "soft_reset_clears_uf");

    c0 = n_crst;
    bus_write(ADDR_CTRL, 32'h1, 4'hF);
    cycles(5);
    bus_read(ADDR_CTRL, 32'h0, "start_empty_key_status");
    chk("start_empty_key_no_crst", n_crst - c0, 0);

    // "Key" reference vector
    exp_key = '{8'h4B, 8'h65, 8'h79};
    load_key(0);
    bus_read(ADDR_CTRL, 32'h0003_0000, "keylen3");
    c0 = n_crst;
    bus_write(ADDR_CTRL, 32'h1, 4'hF);
    cycles(150);
    chk("start_crst_pulse", n_crst - c0, 1);
    bus_read(ADDR_CTRL, 32'h0003_1023, "status_full");
    p0 = n_pulse;
    cycles(10);
    chk("full_stall_no_pulse", n_pulse - p0, 0);
    for (int i = 0; i < 8; i++) bus_read(ADDR_STREAM, {23'h0, 1'b1, lit[i]}, "stream_key_vector");
    cycles(60);
    bus_read(ADDR_COUNT, 32'd24, "count_after_8");
    p0 = n_pulse;
    bus_read(ADDR_STREAM, {23'h0, 1'b1, rc4_byte(exp_key, 8)}, "stream_key_9th");
    cycles(20);
    chk("one_read_one_pulse", n_pulse - p0, 1);
    bus_read(ADDR_CTRL, 32'h0003_1023, "status_refilled");
    c0 = n_crst;
    bus_write(ADDR_CTRL, 32'h1, 4'hF);
    bus_write(ADDR_KEY, 32'hAA, 4'hF);
    cycles(10);
    chk("start_in_gen_no_crst", n_crst - c0, 0);
    bus_read(ADDR_CTRL, 32'h0003_1023, "start_and_key_in_gen_ignored");
    bus_write(ADDR_COUNT, 32'h0, 4'hF);
    bus_read(ADDR_COUNT, 32'h0, "count_cleared");

    // key overflow
    bus_write(ADDR_CTRL, 32'h2, 4'hF);
    bus_read(ADDR_CTRL, 32'h0003_0000, "soft_reset_keeps_key");
    bus_write(ADDR_CTRL, 32'h4, 4'hF);
    bus_read(ADDR_CTRL, 32'h0, "clear_key");
    exp_key.delete();
    for (int i = 0; i < 16; i++) exp_key.push_back(8'($urandom));
    load_key(1);
    bus_read(ADDR_CTRL, 32'h0010_0008, "key_overflow");
    bus_write(ADDR_CTRL, 32'h1, 4'hF);
    cycles(200);
    bus_read(ADDR_CTRL, 32'h0010_102B, "status_full_ovf");
    for (int i = 0; i < 16; i++) bus_read(ADDR_STREAM, {23'h0, 1'b1, rc4_byte(exp_key, i)}, "stream_key16");

    // soft reset in the middle of KEYLOAD
    bus_write(ADDR_CTRL, 32'h2, 4'hF);
    bus_read(ADDR_CTRL, 32'h0010_0000, "soft_reset_from_gen");
    bus_write(ADDR_CTRL, 32'h1, 4'hF);
    cycles(4);
    c0 = n_crst;
    bus_write(ADDR_CTRL, 32'h2, 4'hF);
    cycles(3);
    chk("soft_reset_crst_1cycle", n_crst - c0, 1);
    bus_read(ADDR_CTRL, 32'h0010_0000, "soft_reset_in_keyload");
    bus_read(ADDR_COUNT, 32'h0, "count_after_soft_reset");
    bus_write(ADDR_CTRL, 32'h1, 4'hF);
    cycles(200);
    for (int i = 0; i < 4; i++) bus_read(ADDR_STREAM, {23'h0, 1'b1, rc4_byte(exp_key, i)}, "stream_restart");

    // soft reset beats START; clear key beats START
    bus_write(ADDR_CTRL, 32'h3, 4'hF);
    cycles(5);
    bus_read(ADDR_CTRL, 32'h0010_0000, "soft_reset_over_start");
    c0 = n_crst;
    bus_write(ADDR_CTRL, 32'h5, 4'hF);
    cycles(5);
    chk("clear_key_over_start_no_crst", n_crst - c0, 0);
    bus_read(ADDR_CTRL, 32'h0, "clear_key_over_start");

    // randomized keys and drain lengths
    for (int it = 0; it < 5; it++) begin
      bus_write(ADDR_CTRL, 32'h2, 4'hF);
      bus_write(ADDR_CTRL, 32'h4, 4'hF);
      klen = int'($urandom_range(1, 16));
      nrd  = int'($urandom_range(1, 16));
      exp_key.delete();
      for (int i = 0; i < klen; i++) exp_key.push_back(8'($urandom));
      load_key(0);
      bus_write(ADDR_CTRL, 32'h1, 4'hF);
      cycles(200);
      bus_read(ADDR_CTRL, 32'h0000_1023 | (32'(klen) << 16), "rand_status_full");
      for (int r = 0; r < nrd; r++) begin
        cycles(int'($urandom_range(0, 1)));
        bus_read(ADDR_STREAM, {23'h0, 1'b1, rc4_byte(exp_key, r)}, "rand_stream");
      end
      cycles(80);
      bus_read(ADDR_COUNT, 32'(16 + nrd), "rand_count");
    end

    cycles(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end
endmodule
